reg_load_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one four-bit load-enabled register among
//  NUM_REQ requesters. Grants one requester at a time and aligns the register's

---
 rtl/reg_load_arbiter.sv | 141 ++++++++++++++
 tb/tb_reg_load_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// Round-robin sequencer sharing one load-enabled register among NUM_REQ requesters.
// Loads are aligned to a free-running divided-rate tick used as a clock enable.
module reg_load_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DIV     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     reg_load,
    output logic [WIDTH-1:0]         reg_data,
    output logic                     tick,
    output logic                     busy
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(DIV - 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StLoad, StAck} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 tick_q;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [IdxW-1:0]      last_q, last_d;
    logic [IdxW-1:0]      win;
    logic                 win_found;
    logic [IdxW-1:0]      cand;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 load_q, load_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 busy_q;
    logic [WIDTH-1:0]     data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Free-running tick; registered so it reads 0 while reset is held.
    always_comb begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end

    // Scan last+1, last+2, ... so the requester just served ranks lowest.
    always_comb begin
        win       = last_q;
        win_found = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IdxW'((int'(last_q) + off) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        load_d  = 1'b0;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    idx_d      = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (!req[idx_q]) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end else if (tick_q) begin
                    data_d  = data_arr[idx_q];
                    load_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                gnt_d        = '0;
                ack_d[idx_q] = 1'b1;
                last_d       = idx_q;
                state_d      = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= LastRst;
            gnt_q   <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= (cnt_d == CntMax);
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            data_q  <= data_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign reg_load = load_q;
    assign reg_data = data_q;
    assign tick     = tick_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Scoreboard bench: DUT A (DIV=4) and DUT B (DIV=1) share clock and reset; a transaction-level
// round-robin model predicts the ack order and written data of each request round.
module tb_reg_load_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_a = '0, req_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic [3:0]  gnt_a, ack_a, reg_data_a, gnt_b, ack_b, reg_data_b;
    logic        reg_load_a, tick_a, busy_a, reg_load_b, tick_b, busy_b;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] data;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [1:0] last_a = 2'd3, last_b = 2'd3;
    logic       prev_ld_a = 1'b0, prev_ld_b = 1'b0;

    always #5 clk = ~clk;

    reg_load_arbiter #(.NUM_REQ(4), .WIDTH(4), .DIV(4)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_data(data_a), .gnt(gnt_a), .ack(ack_a),
        .reg_load(reg_load_a), .reg_data(reg_data_a), .tick(tick_a), .busy(busy_a)
    );

    reg_load_arbiter #(.NUM_REQ(4), .WIDTH(4), .DIV(1)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_data(data_b), .gnt(gnt_b), .ack(ack_b),
        .reg_load(reg_load_b), .reg_data(reg_data_b), .tick(tick_b), .busy(busy_b)
    );

    task automatic check(input string name, input bit ok, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requests held until acked: serve the set in round-robin order after the last winner.
    task automatic model(input int d, input logic [3:0] set, input logic [15:0] data);
        logic [3:0] s;
        logic [1:0] last;
        logic [1:0] c;
        exp_t       e;
        s = set;
        last = (d == 0) ? last_a : last_b;
        while (s != 4'd0) begin
            for (int k = 1; k <= 4; k++) begin
                c = 2'((int'(last) + k) % 4);
                if (s[c]) begin
                    e.idx  = c;
                    e.data = data[int'(c)*4 +: 4];
                    if (d == 0) q_a.push_back(e);
                    else q_b.push_back(e);
                    s[c] = 1'b0;
                    last = c;
                    break;
                end
            end
        end
        if (d == 0) last_a = last;
        else last_b = last;
    endtask

    task automatic mon(input int d, input logic [3:0] g, input logic [3:0] a, input logic pl,
                       input logic [3:0] rd);
        exp_t e;
        check(d == 0 ? "props_a" : "props_b",
              $onehot0(g) && $onehot0(a) && ((g & a) == 4'd0) && (a == 4'd0 || pl),
              {24'd0, g, a}, 32'd0);
        if (a != 4'd0) begin
            if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                check("unexpected_ack", 1'b0, {28'd0, a}, 32'd0);
            end else begin
                if (d == 0) e = q_a.pop_front();
                else e = q_b.pop_front();
                check("ack_id", a == (4'b0001 << e.idx), {28'd0, a},
                      {28'd0, 4'b0001 << e.idx});
                check("reg_data", rd == e.data, {28'd0, rd}, {28'd0, e.data});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, gnt_a, ack_a, prev_ld_a, reg_data_a);
            mon(1, gnt_b, ack_b, prev_ld_b, reg_data_b);
        end
        prev_ld_a <= reg_load_a;
        prev_ld_b <= reg_load_b;
    end

    task automatic run_round(input int d, input logic [3:0] set, input logic [15:0] data,
                             input int spacing, input int max_first);
        logic [3:0] pend;
        logic [3:0] a;
        int         cyc;
        int         last_ack;
        bit         first;
        model(d, set, data);
        if (d == 0) begin
            req_a = set;
            data_a = data;
        end else begin
            req_b = set;
            data_b = data;
        end
        pend = set;
        cyc = 0;
        last_ack = 0;
        first = 1'b1;
        while (pend != 4'd0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            a = (d == 0) ? ack_a : ack_b;
            if (a != 4'd0) begin
                if (first) check("first_ack_latency", cyc <= max_first, cyc, max_first);
                else if (spacing > 0) check("ack_spacing", cyc - last_ack == spacing,
                                            cyc - last_ack, spacing);
                first = 1'b0;
                last_ack = cyc;
                pend &= ~a;
                if (d == 0) req_a &= ~a;
                else req_b &= ~a;
            end
        end
        if (pend != 4'd0) begin
            check("round_timeout", 1'b0, {28'd0, pend}, 32'd0);
            req_a = '0;
            req_b = '0;
        end
        @(negedge clk);
        check("busy_after_round", ((d == 0) ? busy_a : busy_b) == 1'b0, 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset values and tick phase after release.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_a", {gnt_a, ack_a, reg_load_a, reg_data_a, tick_a, busy_a} == '0,
              {17'd0, gnt_a, ack_a, reg_load_a, reg_data_a, tick_a, busy_a}, 0);
        check("reset_out_b", {gnt_b, ack_b, reg_load_b, reg_data_b, tick_b, busy_b} == '0,
              {17'd0, gnt_b, ack_b, reg_load_b, reg_data_b, tick_b, busy_b}, 0);
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check("tick_a_phase", tick_a == ((k % 4) == 3), tick_a, (k % 4) == 3);
            check("tick_b_const", tick_b == 1'b1, tick_b, 1);
        end

        // All four requesting, then a single requester.
        run_round(0, 4'b1111, 16'h4321, 0, 7);
        run_round(0, 4'b0001, 16'h000A, 0, 7);

        // Withdraw during GRANT before a tick is seen.
        cyc = 0;
        @(negedge clk);
        while (!tick_a && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        req_a = 4'b0100;
        data_a = 16'h0B00;
        @(negedge clk);
        check("wd_gnt", gnt_a == 4'b0100, gnt_a, 4'b0100);
        check("wd_no_tick", tick_a == 1'b0, tick_a, 0);
        req_a = 4'b0000;
        @(negedge clk);
        check("wd_gnt_drop", gnt_a == 4'b0000, gnt_a, 0);
        check("wd_busy", busy_a == 1'b0, busy_a, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("wd_no_load", reg_load_a == 1'b0, reg_load_a, 0);
        end
        run_round(0, 4'b0110, 16'h0C50, 0, 7);

        // DIV=1 back-to-back service.
        run_round(1, 4'b0011, 16'h00E7, 4, 4);

        for (int r = 0; r < 20; r++) begin
            run_round(0, 4'($urandom_range(1, 15)), 16'($urandom), 0, 7);
            run_round(1, 4'($urandom_range(1, 15)), 16'($urandom), 4, 4);
        end

        // Reset while in LOAD aborts the transfer and restores the pointer.
        req_a = 4'b0010;
        data_a = 16'h00F0;
        cyc = 0;
        @(negedge clk);
        while (!reg_load_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("load_reached", reg_load_a == 1'b1, reg_load_a, 1);
        reset = 1'b1;
        req_a = 4'b0000;
        q_a.delete();
        q_b.delete();
        last_a = 2'd3;
        last_b = 2'd3;
        @(negedge clk);
        check("rst_load", reg_load_a == 1'b0, reg_load_a, 0);
        check("rst_ack", ack_a == 4'd0, ack_a, 0);
        check("rst_data", reg_data_a == 4'd0, reg_data_a, 0);
        check("rst_gnt_busy", {gnt_a, busy_a} == 5'd0, {gnt_a, busy_a}, 0);
        reset = 1'b0;
        @(negedge clk);
        run_round(0, 4'b1000, 16'h7000, 0, 7);
        run_round(0, 4'b0001, 16'h0003, 0, 7);
        run_round(1, 4'b1001, 16'h5006, 4, 4);

        check("queues_empty", q_a.size() == 0 && q_b.size() == 0, q_a.size() + q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
